// File: rtl/cpu_pkg.sv
// Shared definitions for the byte-serial memory access controller: FSM state
// encodings, transfer size constants and 16-bit modulo address helper.
`timescale 1ns/1ps
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;

    // Address of the high byte of a little-endian word; wraps FFFF -> 0000.
    function automatic logic [15:0] addr_inc(input logic [15:0] addr);
        return addr + 16'd1;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response and byte-wide memory bus bundle for mem_access_ctrl.
// slave = controller view, master = requester plus memory environment view.
`timescale 1ns/1ps
interface mem_access_ctrl_if;
    logic [15:0] Address;
    logic [15:0] WData;
    logic        Req;
    logic        WrEn;
    logic        Word;
    logic [15:0] RData;
    logic        Busy;
    logic        Done;
    logic        Err;
    logic [15:0] MemAddr;
    logic [7:0]  MemWData;
    logic [7:0]  MemRData;
    logic        MemCS;
    logic        MemWr;
    logic        MemReady;

    modport slave (
        input  Address, WData, Req, WrEn, Word, MemRData, MemReady,
        output RData, Busy, Done, Err, MemAddr, MemWData, MemCS, MemWr
    );

    modport master (
        output Address, WData, Req, WrEn, Word, MemRData, MemReady,
        input  RData, Busy, Done, Err, MemAddr, MemWData, MemCS, MemWr
    );
endinterface

// File: rtl/mem_wait_timer.sv
// Per-byte wait counter for mem_access_ctrl; o_expired rises once the
// TIMEOUT_CYCLES-th consecutive wait cycle is in progress.
`timescale 1ns/1ps
module mem_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic Clock,
    input  logic Reset,
    input  logic i_clear,
    input  logic i_count_en,
    output logic o_expired
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_count;

    always_ff @(posedge Clock) begin
        if (Reset || i_clear) begin
            r_count <= 8'd0;
        end else if (i_count_en && (r_count != 8'hFF)) begin
            r_count <= r_count + 8'd1;
        end
    end

    // Combinational so the abort lands on the edge closing the last allowed wait cycle.
    assign o_expired = (r_count >= LIMIT);

endmodule

// File: rtl/mem_access_ctrl.sv
// Byte-serial little-endian memory access controller (byte/word, read/write).
// Optional per-byte wait timeout enabled by defining MEM_TIMEOUT_EN.
`timescale 1ns/1ps
module mem_access_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic             Clock,
    input  logic             Reset,
    mem_access_ctrl_if.slave bus
);

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_rdata;
    logic [7:0]  r_lo_byte;
    logic        r_wr;
    logic        r_word;
    logic        w_accept;
    logic        w_expired;
    logic        w_in_xfer;
    logic [15:0] w_addr_hi;

    assign w_in_xfer = (r_state == ST_LO) || (r_state == ST_HI);
    assign w_addr_hi = addr_inc(r_addr);

`ifdef MEM_TIMEOUT_EN
    logic r_err;
    logic w_timer_clear;

    // Restart the count on entry to LO (accept) and on entry to HI.
    assign w_timer_clear = w_accept ||
                           ((r_state == ST_LO) && bus.MemReady && (r_word == SIZE_WORD));

    mem_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .Clock      (Clock),
        .Reset      (Reset),
        .i_clear    (w_timer_clear),
        .i_count_en (w_in_xfer && !bus.MemReady),
        .o_expired  (w_expired)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_in_xfer && !bus.MemReady && w_expired;
        end
    end

    assign bus.Err = (r_state == ST_FIN) && r_err;
`else
    logic w_unused_cfg;

    assign w_unused_cfg = ^8'(TIMEOUT_CYCLES);
    assign w_expired    = 1'b0;
    assign bus.Err      = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.Req) begin
                    w_state_next = ST_LO;
                    w_accept     = 1'b1;
                end
            end
            ST_LO: begin
                if (bus.MemReady) begin
                    w_state_next = (r_word == SIZE_WORD) ? ST_HI : ST_FIN;
                end else if (w_expired) begin
                    w_state_next = ST_FIN;
                end
            end
            ST_HI: begin
                if (bus.MemReady || w_expired) begin
                    w_state_next = ST_FIN;
                end
            end
            ST_FIN:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state   <= ST_IDLE;
            r_addr    <= 16'd0;
            r_wdata   <= 16'd0;
            r_rdata   <= 16'd0;
            r_lo_byte <= 8'd0;
            r_wr      <= 1'b0;
            r_word    <= SIZE_BYTE;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_addr  <= bus.Address;
                r_wdata <= bus.WData;
                r_wr    <= bus.WrEn;
                r_word  <= bus.Word;
            end
            // RData only moves when the final byte of a read completes, so it is
            // already valid in the FIN cycle alongside Done.
            if ((r_state == ST_LO) && bus.MemReady && !r_wr) begin
                if (r_word == SIZE_WORD) begin
                    r_lo_byte <= bus.MemRData;
                end else begin
                    r_rdata <= {8'h00, bus.MemRData};
                end
            end
            if ((r_state == ST_HI) && bus.MemReady && !r_wr) begin
                r_rdata <= {bus.MemRData, r_lo_byte};
            end
        end
    end

    always_comb begin
        bus.MemCS    = 1'b0;
        bus.MemWr    = 1'b0;
        bus.MemAddr  = 16'd0;
        bus.MemWData = 8'd0;
        case (r_state)
            ST_LO: begin
                bus.MemCS    = 1'b1;
                bus.MemWr    = r_wr;
                bus.MemAddr  = r_addr;
                bus.MemWData = r_wdata[7:0];
            end
            ST_HI: begin
                bus.MemCS    = 1'b1;
                bus.MemWr    = r_wr;
                bus.MemAddr  = w_addr_hi;
                bus.MemWData = r_wdata[15:8];
            end
            default: ;
        endcase
    end

    assign bus.RData = r_rdata;
    assign bus.Busy  = (r_state != ST_IDLE);
    assign bus.Done  = (r_state == ST_FIN);

endmodule
